timer_cntr_gen: RTL
===================

# timer_cntr_gen

Parametrised multi-channel timer/counter for the 8051 core SFR space. It is the successor to the fixed two-channel Timer 0/1 block. It provides N_CH independent channels of WIDTH bits, each with free-run, auto-reload, capture and one-shot modes. Each channel can count either from a shared prescaled tick or from a gated external edge, and raises a per-channel interrupt request plus an overflow pulse for baud-rate or cascade use. Registers are accessed through the standard direct-SFR read/write bus.

## Interface
- N_CH, 2, number of channels (1..4)
- WIDTH, 16, counter width in bits (8..16)
- PRESCALE, 12, CPUClock cycles per internal tick (2..255)
- BASE_ADDR, 8'hC0, SFR base; channel c occupies BASE_ADDR+8c+0..4
- CPUClock  in  1  system clock, all state on rising edge
- RESET  in  1  asynchronous, active-high; clock CPUClock
- DIR_RD_ADDRS  in  8  SFR read address
- DIR_WR_ADDRS  in  8  SFR write address
- WR_DATA  in  8  SFR write data
- WR_EN  in  1  write enable
- DIRECT_WR  in  1  direct-address write qualifier; writes require WR_EN & DIRECT_WR
- RD_DATA  out  8  combinational read data
- CNT_IN  in  N_CH  external count pins, rising edge counts
- GATE_IN  in  N_CH  gate pins; high enables counting when GATE=1
- CAP_IN  in  N_CH  capture pins, falling edge captures
- IACK  in  N_CH  interrupt acknowledge, clears OVF and CAPF of the channel
- INT_REQ  out  N_CH  OVF|CAPF per channel
- OVF_PULSE  out  N_CH  one-cycle registered pulse per overflow
- TICK  out  1  registered prescaler pulse

## Operation
- Per-channel registers at offset 0..4:
  - 0: CTRL. Bit[0] RUN; [2:1] MODE (00 free, 01 reload, 10 capture, 11 one-shot); [3] SRC (0 tick, 1 CNT_IN edge); [4] GATE; [5] reserved, reads 0; [6] OVF; [7] CAPF.
  - 1: CNTL. 2: CNTH. 3: RCAPL. 4: RCAPH.
- Bits at or above WIDTH are not stored and read 0. Unmapped addresses read 8'h00.
- Prescaler: counts 0..PRESCALE-1. TICK is high for one cycle when the count wraps, so TICK is period PRESCALE.
- CNT_IN and CAP_IN pass through 2 sampling flops before edge detection.
- Count event: RUN & (SRC ? CNT_IN rising edge : TICK) & (~GATE | GATE_IN).
- Count event with counter at 2^WIDTH-1 is an overflow. The next counter value depends on MODE:
  - free: 0.
  - reload: RCAP.
  - capture: 0.
  - one-shot: RCAP, and RUN clears.
- Every overflow sets OVF and pulses OVF_PULSE.
- Capture mode only: a CAP_IN falling edge copies the current (pre-event) counter value into RCAP and sets CAPF. Outside capture mode, CAP_IN is ignored.
- Write priority:
  - An SFR write to CNTL or CNTH updates that byte and suppresses the channel's count event for that cycle. No overflow occurs in that cycle.
  - A write to RCAP in the same cycle as a capture loses: the capture wins.
  - A CTRL write loads all bits, including the flags. A hardware flag set in the same cycle wins over both the CTRL write and IACK.
- Channels are fully independent. The prescaler is shared.

## Timing
- Reset values: all registers 0, prescaler 0, sampling flops 0; TICK, INT_REQ and OVF_PULSE all 0. RD_DATA reflects the zeroed registers.
- Register writes take effect at the CPUClock edge where WR_EN & DIRECT_WR are high. Reads are combinational in the same cycle.
- First TICK after reset deassertion: high during cycle PRESCALE, i.e. after PRESCALE edges.
- Counter update: at the edge ending the cycle in which the count event is true.
- External edge latency: the counter changes on the 2nd rising edge after the first edge that samples CNT_IN high. Capture uses the same 2-edge latency.
- OVF, CAPF and INT_REQ go high at the same edge as the wrap or capture. OVF_PULSE is high for exactly that following cycle.
- IACK clears flags at the next edge.
- Asserting RESET mid-count forces all state to reset values immediately, without waiting for a clock edge.

## Test plan
- Prescaler: PRESCALE=12 → TICK is high every 12th cycle, first pulse at cycle 12 after reset release.
- Free-run overflow: WIDTH=16, ch0 CTRL=8'h01, CNT=16'hFFFE → after 2 ticks CNT=0, OVF=1, INT_REQ[0]=1, one OVF_PULSE. IACK → INT_REQ[0]=0.
- Auto-reload and one-shot:
  - Reload: ch1 MODE=01, RCAP=16'hFF00, CNT=16'hFFFF, one tick → CNT=16'hFF00.
  - One-shot: MODE=11 with the same values → CNT=16'hFF00, RUN=0, and no further counting.
- Capture and gating: ch0 MODE=10, SRC=1, GATE=1.
  - GATE_IN=0: 5 CNT_IN pulses → CNT unchanged.
  - GATE_IN=1: 5 pulses → CNT=5.
  - Then a CAP_IN falling edge → RCAP=5, CAPF=1.
- Collisions:
  - Write CNTL=8'h10 in a tick cycle → CNTL=8'h10 with no increment.
  - Overflow in the same cycle as IACK → OVF stays 1.
  - Overflow in the same cycle as a CTRL write of 8'h01 → OVF=1.
- Width and reset: WIDTH=8 → CNTH reads 0 and writes to it are ignored; overflow occurs at 8'hFF. RESET mid-count → all outputs and registers read 0.

Source files
------------

// File: rtl/timer_cntr_gen_if.sv
// SFR direct-address bus between the 8051 core (master) and a peripheral (slave).
//   DIR_RD_ADDRS : read address, RD_DATA returns combinationally
//   DIR_WR_ADDRS : write address
//   WR_DATA      : write data
//   WR_EN        : write enable
//   DIRECT_WR    : direct-address qualifier; a write needs WR_EN & DIRECT_WR
//   RD_DATA      : read data from the slave
interface timer_cntr_gen_if;
  logic [7:0] DIR_RD_ADDRS;
  logic [7:0] DIR_WR_ADDRS;
  logic [7:0] WR_DATA;
  logic       WR_EN;
  logic       DIRECT_WR;
  logic [7:0] RD_DATA;

  modport master (
    output DIR_RD_ADDRS,
    output DIR_WR_ADDRS,
    output WR_DATA,
    output WR_EN,
    output DIRECT_WR,
    input  RD_DATA
  );

  modport slave (
    input  DIR_RD_ADDRS,
    input  DIR_WR_ADDRS,
    input  WR_DATA,
    input  WR_EN,
    input  DIRECT_WR,
    output RD_DATA
  );
endinterface

// File: rtl/timer_cntr_gen.sv
// Multi-channel timer/counter in the 8051 SFR space.
// N_CH channels of WIDTH bits; modes free-run, auto-reload, capture, one-shot.
// Ports:
//   CPUClock, RESET : clock, asynchronous active-high reset
//   sfr_bus         : SFR read/write bus (slave); channel c at BASE_ADDR+8c+0..4
//   CNT_IN          : external count pins (rising edge counts when SRC=1)
//   GATE_IN         : gate pins (enable counting when GATE=1)
//   CAP_IN          : capture pins (falling edge, capture mode only)
//   IACK            : interrupt acknowledge, clears OVF/CAPF
//   INT_REQ         : OVF | CAPF per channel
//   OVF_PULSE       : one-cycle pulse per overflow
//   TICK            : shared prescaler pulse, period PRESCALE
module timer_cntr_gen #(
  parameter int unsigned N_CH      = 2,
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned PRESCALE  = 12,
  parameter logic [7:0]  BASE_ADDR = 8'hC0
) (
  input  logic             CPUClock,
  input  logic             RESET,
  timer_cntr_gen_if.slave  sfr_bus,
  input  logic [N_CH-1:0]  CNT_IN,
  input  logic [N_CH-1:0]  GATE_IN,
  input  logic [N_CH-1:0]  CAP_IN,
  input  logic [N_CH-1:0]  IACK,
  output logic [N_CH-1:0]  INT_REQ,
  output logic [N_CH-1:0]  OVF_PULSE,
  output logic             TICK
);

  localparam logic [1:0] ModeFree    = 2'b00;
  localparam logic [1:0] ModeReload  = 2'b01;
  localparam logic [1:0] ModeCapture = 2'b10;
  localparam logic [1:0] ModeOneShot = 2'b11;

  logic       wr_en;
  logic [7:0] presc_q, presc_d;
  logic       tick_q, tick_d;
  logic [7:0] rd_ch [N_CH];
  logic [7:0] rd_data;

  assign wr_en = sfr_bus.WR_EN & sfr_bus.DIRECT_WR;

  // Shared prescaler: TICK is registered, high in the cycle after the count wraps.
  always_comb begin
    tick_d  = 1'b0;
    presc_d = presc_q + 8'd1;
    if (presc_q == 8'(PRESCALE - 1)) begin
      presc_d = 8'd0;
      tick_d  = 1'b1;
    end
  end

  always_ff @(posedge CPUClock or posedge RESET) begin
    if (RESET) begin
      presc_q <= 8'd0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
    end
  end

  assign TICK = tick_q;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    localparam logic [7:0] ChBase = BASE_ADDR + 8'(8 * c);

    logic             run_q, run_d, src_q, src_d, gate_q, gate_d;
    logic             ovf_q, ovf_d, capf_q, capf_d;
    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] cnt_q, cnt_d, rcap_q, rcap_d;
    logic             ovf_pulse_q, ovf_pulse_d;
    // Bit 0 newest; bits 1/2 feed the edge detector after two sampling stages.
    logic [2:0]       cnt_sync_q, cnt_sync_d, cap_sync_q, cap_sync_d;

    logic [7:0]  wr_off, rd_off;
    logic        wr_ctrl, wr_cntl, wr_cnth, wr_rcapl, wr_rcaph;
    logic        cnt_rise, cap_fall, count_ev, wrap, cap_ev;
    logic [15:0] cnt_wide, rcap_wide;
    logic [7:0]  rd_val;

    assign wr_off   = sfr_bus.DIR_WR_ADDRS - ChBase;
    assign rd_off   = sfr_bus.DIR_RD_ADDRS - ChBase;
    assign wr_ctrl  = wr_en & (wr_off == 8'd0);
    assign wr_cntl  = wr_en & (wr_off == 8'd1);
    assign wr_cnth  = wr_en & (wr_off == 8'd2);
    assign wr_rcapl = wr_en & (wr_off == 8'd3);
    assign wr_rcaph = wr_en & (wr_off == 8'd4);

    assign cnt_rise = cnt_sync_q[1] & ~cnt_sync_q[2];
    assign cap_fall = ~cap_sync_q[1] & cap_sync_q[2];

    // A CPU write to the counter owns the cycle: no count, hence no overflow.
    assign count_ev = run_q & (src_q ? cnt_rise : tick_q) & (~gate_q | GATE_IN[c])
                    & ~(wr_cntl | wr_cnth);
    assign wrap     = count_ev & (&cnt_q);
    assign cap_ev   = (mode_q == ModeCapture) & cap_fall;

    always_comb begin
      cnt_sync_d  = {cnt_sync_q[1:0], CNT_IN[c]};
      cap_sync_d  = {cap_sync_q[1:0], CAP_IN[c]};
      ovf_pulse_d = wrap;

      cnt_wide = 16'(cnt_q);
      if (wr_cntl) begin
        cnt_wide[7:0] = sfr_bus.WR_DATA;
      end else if (wr_cnth) begin
        cnt_wide[15:8] = sfr_bus.WR_DATA;
      end else if (count_ev) begin
        if (!wrap) begin
          cnt_wide = 16'(cnt_q) + 16'd1;
        end else if (mode_q == ModeReload || mode_q == ModeOneShot) begin
          cnt_wide = 16'(rcap_q);
        end else begin
          cnt_wide = 16'd0;
        end
      end
      cnt_d = cnt_wide[WIDTH-1:0];

      rcap_wide = 16'(rcap_q);
      if (wr_rcapl) rcap_wide[7:0]  = sfr_bus.WR_DATA;
      if (wr_rcaph) rcap_wide[15:8] = sfr_bus.WR_DATA;
      // Capture takes the pre-event count and beats a concurrent RCAP write.
      if (cap_ev) rcap_wide = 16'(cnt_q);
      rcap_d = rcap_wide[WIDTH-1:0];

      run_d  = run_q;
      mode_d = mode_q;
      src_d  = src_q;
      gate_d = gate_q;
      ovf_d  = ovf_q;
      capf_d = capf_q;
      if (wr_ctrl) begin
        run_d  = sfr_bus.WR_DATA[0];
        mode_d = sfr_bus.WR_DATA[2:1];
        src_d  = sfr_bus.WR_DATA[3];
        gate_d = sfr_bus.WR_DATA[4];
        ovf_d  = sfr_bus.WR_DATA[6];
        capf_d = sfr_bus.WR_DATA[7];
      end
      if (IACK[c]) begin
        ovf_d  = 1'b0;
        capf_d = 1'b0;
      end
      // Hardware events are applied last so they win over CPU writes and IACK.
      if (wrap) begin
        ovf_d = 1'b1;
        if (mode_q == ModeOneShot) run_d = 1'b0;
      end
      if (cap_ev) capf_d = 1'b1;
    end

    always_ff @(posedge CPUClock or posedge RESET) begin
      if (RESET) begin
        run_q       <= 1'b0;
        mode_q      <= ModeFree;
        src_q       <= 1'b0;
        gate_q      <= 1'b0;
        ovf_q       <= 1'b0;
        capf_q      <= 1'b0;
        cnt_q       <= '0;
        rcap_q      <= '0;
        ovf_pulse_q <= 1'b0;
        cnt_sync_q  <= 3'b000;
        cap_sync_q  <= 3'b000;
      end else begin
        run_q       <= run_d;
        mode_q      <= mode_d;
        src_q       <= src_d;
        gate_q      <= gate_d;
        ovf_q       <= ovf_d;
        capf_q      <= capf_d;
        cnt_q       <= cnt_d;
        rcap_q      <= rcap_d;
        ovf_pulse_q <= ovf_pulse_d;
        cnt_sync_q  <= cnt_sync_d;
        cap_sync_q  <= cap_sync_d;
      end
    end

    always_comb begin
      rd_val = 8'h00;
      case (rd_off)
        8'd0:    rd_val = {capf_q, ovf_q, 1'b0, gate_q, src_q, mode_q, run_q};
        8'd1:    rd_val = 16'(cnt_q) >> 0;
        8'd2:    rd_val = 8'(16'(cnt_q) >> 8);
        8'd3:    rd_val = 16'(rcap_q) >> 0;
        8'd4:    rd_val = 8'(16'(rcap_q) >> 8);
        default: rd_val = 8'h00;
      endcase
    end

    assign rd_ch[c]     = rd_val;
    assign INT_REQ[c]   = ovf_q | capf_q;
    assign OVF_PULSE[c] = ovf_pulse_q;
  end

  always_comb begin
    rd_data = 8'h00;
    for (int i = 0; i < N_CH; i++) rd_data = rd_data | rd_ch[i];
  end

  assign sfr_bus.RD_DATA = rd_data;

endmodule
